// File: rtl/line_raster_pkg.sv
// Shared types and helpers for the line rasteriser and related primitives.
package line_raster_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE
    } state_t;

    localparam int COORD_W = 16;

    typedef logic signed [COORD_W-1:0] coord_t;

    // Error accumulator width: two extra bits keep 2*err and dx/dy sums in range.
    function automatic int err_w(input int size);
        return size + 2;
    endfunction

endpackage

// File: rtl/line_raster_engine_viewport_clip.sv
// Combinational viewport test: true when (x,y) lies inside 0..XRES-1 x 0..YRES-1.
module viewport_clip
    import line_raster_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int XRES = 640,
    parameter int YRES = 480
) (
    input  logic signed [SIZE-1:0] x,
    input  logic signed [SIZE-1:0] y,
    output logic                   in_view
);

    localparam logic [SIZE:0] X_LIM = (SIZE+1)'(XRES);
    localparam logic [SIZE:0] Y_LIM = (SIZE+1)'(YRES);

    // Non-negative and below the limit on both axes.
    always_comb begin
        in_view = !x[SIZE-1] && ({1'b0, x} < X_LIM) &&
                  !y[SIZE-1] && ({1'b0, y} < Y_LIM);
    end

endmodule

// File: rtl/line_raster_engine.sv
// Single-datapath Bresenham line rasteriser for all octants, streaming
// pixels over valid/ready with optional viewport clipping and abort.
module line_raster_engine
    import line_raster_pkg::*;
#(
    parameter int SIZE    = 16,
    parameter int XRES    = 640,
    parameter int YRES    = 480,
    parameter int CLIP_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_enb,
    input  logic                   start,
    input  logic signed [SIZE-1:0] x0,
    input  logic signed [SIZE-1:0] y0,
    input  logic signed [SIZE-1:0] x1,
    input  logic signed [SIZE-1:0] y1,
    input  logic                   abort,
    output logic                   busy,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic signed [SIZE-1:0] pix_x,
    output logic signed [SIZE-1:0] pix_y,
    output logic                   pix_last,
    output logic                   done
);

    localparam int EW = err_w(SIZE);
    localparam logic signed [SIZE-1:0] ONE    = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0]   ZERO_E = '0;

    state_t state, state_nxt;

    logic signed [SIZE-1:0] cx, cy, ex, ey;
    logic signed [SIZE-1:0] cx_nxt, cy_nxt, ex_nxt, ey_nxt;
    logic signed [EW-1:0]   dx, dy, err;
    logic signed [EW-1:0]   dx_nxt, dy_nxt, err_nxt;
    logic                   sx_neg, sy_neg, sx_neg_nxt, sy_neg_nxt;
    logic                   busy_nxt, pix_valid_nxt, pix_last_nxt, done_nxt;
    logic signed [SIZE-1:0] pix_x_nxt, pix_y_nxt;

    logic signed [EW-1:0]   ddx, ddy, adx, ady;
    logic signed [EW:0]     e2, dx_ext, dy_ext;
    logic                   step_x, step_y;
    logic signed [SIZE-1:0] ncx, ncy;
    logic signed [EW-1:0]   nerr;
    logic                   cur_in, nxt_in, cur_vis, nxt_vis, is_end, nxt_end, advance;

    viewport_clip #(.SIZE(SIZE), .XRES(XRES), .YRES(YRES)) u_clip_cur (
        .x       (cx),
        .y       (cy),
        .in_view (cur_in)
    );

    viewport_clip #(.SIZE(SIZE), .XRES(XRES), .YRES(YRES)) u_clip_nxt (
        .x       (ncx),
        .y       (ncy),
        .in_view (nxt_in)
    );

    // Setup deltas, Bresenham step decision and the next point on the line.
    always_comb begin
        ddx     = {{2{ex[SIZE-1]}}, ex} - {{2{cx[SIZE-1]}}, cx};
        ddy     = {{2{ey[SIZE-1]}}, ey} - {{2{cy[SIZE-1]}}, cy};
        adx     = ddx[EW-1] ? -ddx : ddx;
        ady     = ddy[EW-1] ? -ddy : ddy;
        e2      = {err, 1'b0};
        dx_ext  = {dx[EW-1], dx};
        dy_ext  = {dy[EW-1], dy};
        step_x  = (e2 >= dy_ext);
        step_y  = (e2 <= dx_ext);
        nerr    = err + (step_x ? dy : ZERO_E) + (step_y ? dx : ZERO_E);
        ncx     = step_x ? (sx_neg ? cx - ONE : cx + ONE) : cx;
        ncy     = step_y ? (sy_neg ? cy - ONE : cy + ONE) : cy;
        cur_vis = (CLIP_EN == 0) || cur_in;
        nxt_vis = (CLIP_EN == 0) || nxt_in;
        is_end  = (cx == ex) && (cy == ey);
        nxt_end = (ncx == ex) && (ncy == ey);
        // The presented pixel always mirrors (cx,cy); a clipped point has
        // pix_valid low and so moves on without waiting for the consumer.
        advance = !pix_valid || pix_ready;
    end

    // Next-state and next-register logic; abort overrides everything outside IDLE.
    always_comb begin
        state_nxt     = state;
        cx_nxt        = cx;
        cy_nxt        = cy;
        ex_nxt        = ex;
        ey_nxt        = ey;
        dx_nxt        = dx;
        dy_nxt        = dy;
        err_nxt       = err;
        sx_neg_nxt    = sx_neg;
        sy_neg_nxt    = sy_neg;
        busy_nxt      = busy;
        pix_valid_nxt = pix_valid;
        pix_last_nxt  = pix_last;
        pix_x_nxt     = pix_x;
        pix_y_nxt     = pix_y;
        done_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    cx_nxt    = x0;
                    cy_nxt    = y0;
                    ex_nxt    = x1;
                    ey_nxt    = y1;
                    busy_nxt  = 1'b1;
                end
            end
            SETUP: begin
                dx_nxt        = adx;
                dy_nxt        = -ady;
                err_nxt       = adx - ady;
                sx_neg_nxt    = ddx[EW-1];
                sy_neg_nxt    = ddy[EW-1];
                pix_valid_nxt = cur_vis;
                pix_x_nxt     = cx;
                pix_y_nxt     = cy;
                pix_last_nxt  = cur_vis && is_end;
                state_nxt     = DRAW;
            end
            DRAW: begin
                if (advance) begin
                    if (is_end) begin
                        state_nxt     = DONE;
                        pix_valid_nxt = 1'b0;
                        pix_last_nxt  = 1'b0;
                        done_nxt      = 1'b1;
                    end else begin
                        cx_nxt        = ncx;
                        cy_nxt        = ncy;
                        err_nxt       = nerr;
                        pix_valid_nxt = nxt_vis;
                        pix_x_nxt     = ncx;
                        pix_y_nxt     = ncy;
                        pix_last_nxt  = nxt_vis && nxt_end;
                    end
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort && (state != IDLE)) begin
            state_nxt     = IDLE;
            pix_valid_nxt = 1'b0;
            pix_last_nxt  = 1'b0;
            busy_nxt      = 1'b0;
            done_nxt      = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clk_enb) begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx        <= '0;
            cy        <= '0;
            ex        <= '0;
            ey        <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            done      <= 1'b0;
        end else if (clk_enb) begin
            cx        <= cx_nxt;
            cy        <= cy_nxt;
            ex        <= ex_nxt;
            ey        <= ey_nxt;
            dx        <= dx_nxt;
            dy        <= dy_nxt;
            err       <= err_nxt;
            sx_neg    <= sx_neg_nxt;
            sy_neg    <= sy_neg_nxt;
            busy      <= busy_nxt;
            pix_valid <= pix_valid_nxt;
            pix_last  <= pix_last_nxt;
            pix_x     <= pix_x_nxt;
            pix_y     <= pix_y_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed testbench for line_raster_engine.
module tb_line_raster_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_enb = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic pix_ready = 1'b0;
    logic signed [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic busy, pix_valid, pix_last, done;
    logic signed [15:0] pix_x, pix_y;

    int errors = 0;
    int checks = 0;

    logic [31:0] pq[$];
    int last_cnt, last_idx, n_done, done_cyc, first_valid, stall_obs, stall_bad;
    bit timed_out;

    line_raster_engine #(.SIZE(16), .XRES(640), .YRES(480), .CLIP_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_enb   (clk_enb),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .abort     (abort),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int x, input int y);
        return {x[15:0], y[15:0]};
    endfunction

    // Launch one line and record every transferred pixel until busy drops.
    // ready_mode 1 stalls 3 cycles at (1,1); enb_mode 1 toggles clk_enb;
    // abort_after>0 raises abort on the cycle of that accepted pixel;
    // hold_start keeps start high with other coordinates while busy.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int ready_mode, input int enb_mode,
                            input int abort_after, input int hold_start);
        int n, stall_left, acc;
        bit stalled;
        pq.delete();
        last_cnt = 0; last_idx = -1; n_done = 0; done_cyc = -1; first_valid = -1;
        stall_obs = 0; stall_bad = 0; timed_out = 1'b1;
        stall_left = 0; stalled = 1'b0; acc = 0;
        @(negedge clk);
        x0 = ax0[15:0]; y0 = ay0[15:0]; x1 = ax1[15:0]; y1 = ay1[15:0];
        start = 1'b1; clk_enb = 1'b1; pix_ready = 1'b1; abort = 1'b0;
        @(negedge clk);
        if (hold_start != 0) begin
            x0 = 16'sd5; y0 = 16'sd5; x1 = 16'sd6; y1 = 16'sd5;
        end else begin
            start = 1'b0;
        end
        n = 1;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                @(negedge clk);
                n++;
            end
            abort = 1'b0;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            clk_enb = (enb_mode == 0) ? 1'b1 : ((n % 2) == 1);
            if (ready_mode == 1 && !stalled && pix_valid && pix_x == 1 && pix_y == 1) begin
                stall_left = 3;
                stalled = 1'b1;
            end
            if (stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
                stall_obs++;
                if (!(pix_valid === 1'b1 && pix_x === 16'sd1 && pix_y === 16'sd1)) stall_bad++;
            end else begin
                pix_ready = 1'b1;
            end
            if (pix_valid && first_valid < 0) first_valid = n;
            if (clk_enb && pix_valid && pix_ready) begin
                if (pix_last) begin
                    last_cnt++;
                    last_idx = pq.size();
                end
                pq.push_back({pix_x, pix_y});
                acc++;
                if (abort_after > 0 && acc == abort_after) abort = 1'b1;
            end
            if (clk_enb && done) begin
                n_done++;
                done_cyc = n;
            end
        end
        start = 1'b0; abort = 1'b0; clk_enb = 1'b1; pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, pix_valid, pix_last, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {busy, pix_valid, pix_last, done});
        end
        checks++;
        if ({pix_x, pix_y} !== 32'h0) begin
            errors++;
            $display("FAIL reset_xy: got %h want 00000000", {pix_x, pix_y});
        end
        rst_n = 1'b1;
        clk_enb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_horizontal();
        logic [31:0] exp[$];
        exp = '{pk(0,0), pk(1,0), pk(2,0), pk(3,0)};
        run_line(0, 0, 3, 0, 0, 0, 0, 0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL horiz_timeout: busy still %b want 0", busy); end
        checks++;
        if (pq.size() != exp.size()) begin
            errors++; $display("FAIL horiz_count: got %0d want %0d", pq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (pq[i] !== exp[i]) begin errors++; $display("FAIL horiz_pix%0d: got %h want %h", i, pq[i], exp[i]); end
            end
        end
        checks++;
        if (first_valid !== 2) begin errors++; $display("FAIL horiz_latency: got %0d want 2", first_valid); end
        checks++;
        if (last_cnt !== 1 || last_idx !== 3) begin errors++; $display("FAIL horiz_last: got cnt %0d idx %0d want 1/3", last_cnt, last_idx); end
        checks++;
        if (n_done !== 1 || done_cyc !== 6) begin errors++; $display("FAIL horiz_done: got cnt %0d cyc %0d want 1/6", n_done, done_cyc); end
    endtask

    task automatic test_steep();
        logic [31:0] exp[$];
        exp = '{pk(2,5), pk(2,4), pk(1,3), pk(1,2), pk(0,1), pk(0,0)};
        run_line(2, 5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pq.size() != exp.size()) begin
            errors++; $display("FAIL steep_count: got %0d want %0d", pq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (pq[i] !== exp[i]) begin errors++; $display("FAIL steep_pix%0d: got %h want %h", i, pq[i], exp[i]); end
            end
        end
        checks++;
        if (last_cnt !== 1 || last_idx !== 5 || n_done !== 1) begin
            errors++; $display("FAIL steep_end: got last %0d idx %0d done %0d want 1/5/1", last_cnt, last_idx, n_done);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp[$];
        exp = '{pk(0,0), pk(1,1), pk(2,2)};
        for (int unsigned m = 0; m < 2; m++) begin
            if (m == 0) run_line(0, 0, 2, 2, 1, 0, 0, 0);
            else        run_line(0, 0, 2, 2, 0, 1, 0, 0);
            checks++;
            if (pq.size() != exp.size()) begin
                errors++; $display("FAIL bp%0d_count: got %0d want %0d", m, pq.size(), exp.size());
            end else begin
                for (int i = 0; i < exp.size(); i++) begin
                    checks++;
                    if (pq[i] !== exp[i]) begin errors++; $display("FAIL bp%0d_pix%0d: got %h want %h", m, i, pq[i], exp[i]); end
                end
            end
            checks++;
            if (n_done !== 1 || last_idx !== 2) begin errors++; $display("FAIL bp%0d_end: got done %0d idx %0d want 1/2", m, n_done, last_idx); end
        end
        checks++;
        if (stall_obs != 0) begin errors++; $display("FAIL bp_enb_nostall: got %0d want 0", stall_obs); end
    endtask

    task automatic test_stall_hold();
        run_line(0, 0, 2, 2, 1, 0, 0, 0);
        checks++;
        if (stall_obs !== 3 || stall_bad !== 0) begin
            errors++; $display("FAIL stall_hold: got obs %0d bad %0d want 3/0", stall_obs, stall_bad);
        end
    endtask

    task automatic test_clip();
        logic [31:0] exp[$];
        exp = '{pk(0,0), pk(1,0), pk(2,0)};
        run_line(-2, 0, 2, 0, 0, 0, 0, 0);
        checks++;
        if (pq.size() != exp.size()) begin
            errors++; $display("FAIL clip_count: got %0d want %0d", pq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (pq[i] !== exp[i]) begin errors++; $display("FAIL clip_pix%0d: got %h want %h", i, pq[i], exp[i]); end
            end
        end
        checks++;
        if (last_idx !== 2 || n_done !== 1) begin errors++; $display("FAIL clip_end: got idx %0d done %0d want 2/1", last_idx, n_done); end
        run_line(637, 0, 641, 0, 0, 0, 0, 0);
        checks++;
        if (pq.size() !== 3 || last_cnt !== 0 || n_done !== 1) begin
            errors++; $display("FAIL clip_endpoint: got n %0d last %0d done %0d want 3/0/1", pq.size(), last_cnt, n_done);
        end
        run_line(700, 10, 705, 10, 0, 0, 0, 0);
        checks++;
        if (pq.size() !== 0 || n_done !== 1 || timed_out) begin
            errors++; $display("FAIL clip_full: got n %0d done %0d to %0d want 0/1/0", pq.size(), n_done, timed_out);
        end
    endtask

    task automatic test_degenerate();
        run_line(7, 7, 7, 7, 0, 0, 0, 0);
        checks++;
        if (pq.size() !== 1 || last_idx !== 0 || n_done !== 1) begin
            errors++; $display("FAIL degen: got n %0d idx %0d done %0d want 1/0/1", pq.size(), last_idx, n_done);
        end else begin
            checks++;
            if (pq[0] !== pk(7,7)) begin errors++; $display("FAIL degen_pix: got %h want %h", pq[0], pk(7,7)); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] exp[$];
        exp = '{pk(0,0), pk(1,0), pk(2,0)};
        run_line(0, 0, 9, 0, 0, 0, 3, 0);
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || n_done !== 0) begin
            errors++; $display("FAIL abort_state: got valid %b busy %b done %0d want 0/0/0", pix_valid, busy, n_done);
        end
        checks++;
        if (pq.size() != exp.size()) begin
            errors++; $display("FAIL abort_count: got %0d want %0d", pq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (pq[i] !== exp[i]) begin errors++; $display("FAIL abort_pix%0d: got %h want %h", i, pq[i], exp[i]); end
            end
        end
        run_line(0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (pq.size() !== 2 || n_done !== 1 || last_idx !== 1) begin
            errors++; $display("FAIL abort_restart: got n %0d done %0d idx %0d want 2/1/1", pq.size(), n_done, last_idx);
        end
    endtask

    task automatic test_reset_midline();
        bit saw_done;
        @(negedge clk);
        x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd9; y1 = 16'sd0;
        start = 1'b1; clk_enb = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got valid %b busy %b want 1/1", pix_valid, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, pix_valid, pix_last, done, pix_x, pix_y} !== 36'h0) begin
            errors++; $display("FAIL midrst_outputs: got %h want 0", {busy, pix_valid, pix_last, done, pix_x, pix_y});
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL midrst_idle: got busy/done activity 1 want 0"); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] exp[$];
        exp = '{pk(0,0), pk(1,0), pk(2,0), pk(3,0)};
        run_line(0, 0, 3, 0, 0, 0, 0, 1);
        checks++;
        if (pq.size() != exp.size()) begin
            errors++; $display("FAIL busy_start_count: got %0d want %0d", pq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (pq[i] !== exp[i]) begin errors++; $display("FAIL busy_start_pix%0d: got %h want %h", i, pq[i], exp[i]); end
            end
        end
        checks++;
        if (n_done !== 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_end: got done %0d busy %b want 1/0", n_done, busy); end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_backpressure();
        test_stall_hold();
        test_clip();
        test_degenerate();
        test_abort();
        test_reset_midline();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
